// File: rtl/x_debounce_filter_if.sv
// Signal bundle between the debounce filter and its user: raw strobe and
// counter clear in, clean level, edge pulses, glitch count and busy out.
interface x_debounce_filter_if #(
   parameter int CNT_W = 8
);
   logic             XRaw;
   logic             ClrCnt;
   logic             XClean;
   logic             FallPulse;
   logic             RisePulse;
   logic [CNT_W-1:0] GlitchCnt;
   logic             Busy;

   modport master (
      output XRaw, ClrCnt,
      input  XClean, FallPulse, RisePulse, GlitchCnt, Busy
   );

   modport slave (
      input  XRaw, ClrCnt,
      output XClean, FallPulse, RisePulse, GlitchCnt, Busy
   );
endinterface

// File: rtl/x_debounce_filter.sv
// Synchronises the active-low XRaw strobe and accepts a level change only after
// STABLE_CYCLES consecutive agreeing samples; rejected pulses are counted.
module x_debounce_filter #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input logic                Clk,
   input logic                RstN,
   x_debounce_filter_if.slave sig
);
   localparam int            CW       = $clog2(STABLE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   // Bit 1 = clean level is low, bit 0 = change pending: XClean and Busy are plain state bits.
   typedef enum logic [1:0] {
      S_HIGH      = 2'b00,
      S_PEND_LOW  = 2'b01,
      S_LOW       = 2'b10,
      S_PEND_HIGH = 2'b11
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [CW-1:0]          cnt;
   logic [CW-1:0]          cnt_nxt;
   logic [SYNC_STAGES-1:0] sync;
   logic                   xs;
   logic                   fall_nxt;
   logic                   rise_nxt;
   logic                   glitch;
   logic                   fall_r;
   logic                   rise_r;
   logic [CNT_W-1:0]       gcnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Synchroniser: XRaw goes straight into the first flop.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         sync <= '1;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], sig.XRaw};
      end
   end

   assign xs = sync[SYNC_STAGES-1];

   // State register, stability counter and registered edge pulses.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         state  <= S_HIGH;
         cnt    <= '0;
         fall_r <= 1'b0;
         rise_r <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         fall_r <= fall_nxt;
         rise_r <= rise_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      fall_nxt  = 1'b0;
      rise_nxt  = 1'b0;
      glitch    = 1'b0;
      case (state)
         S_HIGH: begin
            if (!xs) begin
               state_nxt = S_PEND_LOW;
               cnt_nxt   = CNT_ONE;
            end
         end
         S_PEND_LOW: begin
            if (xs) begin
               state_nxt = S_HIGH;
               cnt_nxt   = '0;
               glitch    = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_nxt = S_LOW;
               cnt_nxt   = '0;
               fall_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         S_LOW: begin
            if (xs) begin
               state_nxt = S_PEND_HIGH;
               cnt_nxt   = CNT_ONE;
            end
         end
         S_PEND_HIGH: begin
            if (!xs) begin
               state_nxt = S_LOW;
               cnt_nxt   = '0;
               glitch    = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_nxt = S_HIGH;
               cnt_nxt   = '0;
               rise_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
      endcase
   end

   always_comb begin
      sig.XClean    = ~state[1];
      sig.Busy      = state[0];
      sig.FallPulse = fall_r;
      sig.RisePulse = rise_r;
      sig.GlitchCnt = gcnt;
   end

   // A clear wins over a glitch landing on the same edge; that glitch is dropped.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         gcnt <= '0;
      end else if (sig.ClrCnt) begin
         gcnt <= '0;
      end else if (glitch) begin
         gcnt <= sat_inc(gcnt);
      end
   end
endmodule
